mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LIMIT, default 255, SHALL give the highest valid byte address of the attached RAM.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 i_req, i_addr  input  1, 32  instruction-fetch read request and byte address; port I is read-only, always a full word.
REQ-005 i_ack, i_err, i_rdata  output  1, 1, 32  port I completion pulse, error flag and read data.
REQ-006 d_req, d_we, d_word, d_sign  input  1 each  data-port request; 1 = write / full word / signed.
REQ-007 d_addr, d_wdata  input  32, 32  data-port byte address and write data.
REQ-008 d_ack, d_err, d_rdata  output  1, 1, 32  port D completion pulse, error flag and read data.
REQ-009 ram_read, ram_write, ram_word, ram_sign  output  1 each  RAM control strobes.
REQ-010 ram_address, ram_dataIn  output  32, 32  RAM address and write data.
REQ-011 ram_dataOut  input  32  RAM read data, valid from the edge after ram_read is sampled.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM SHALL have states IDLE, ISSUE, WAIT and DONE; every state except IDLE SHALL advance unconditionally: ISSUE->WAIT->DONE->IDLE.
REQ-014 In IDLE, with at least one req high, the FSM SHALL grant one port, latch that port's address, data and control, and enter ISSUE; otherwise it SHALL stay in IDLE.
REQ-015 If both reqs are high, the grant SHALL go to the port not granted last (round-robin); after reset, port D SHALL win the first tie.
REQ-016 Request inputs SHALL be ignored outside IDLE; latched values SHALL not change mid-transaction.
REQ-017 In ISSUE, ram_read or ram_write SHALL be high for exactly that one cycle; in all other states both SHALL be 0.
REQ-018 ram_address and ram_dataIn SHALL hold the latched values from ISSUE through DONE.
REQ-019 All reads SHALL drive ram_word=1 and ram_sign=0; the arbiter SHALL perform half-word extension itself, never relying on RAM upper bits.
REQ-020 Read data SHALL be registered from ram_dataOut at the WAIT->DONE edge.
REQ-021 Full-word reads SHALL return ram_dataOut unchanged.
REQ-022 Half-word reads SHALL return ram_dataOut[15:0], zero-extended if d_sign=0 or sign-extended from bit 15 if d_sign=1.
REQ-023 Writes SHALL require d_word=1; the RAM stores 4 bytes, little-endian.
REQ-024 An access SHALL be an error if it is a half-word write, a word access with addr+3 > MEM_LIMIT, or a half-word read with addr+1 > MEM_LIMIT.
REQ-025 Address-limit arithmetic SHALL use 33 bits so that 32-bit wrap counts as out of range.
REQ-026 An error access SHALL follow the same state sequence but assert no RAM strobe, return rdata 0 and pulse err with ack.
REQ-027 The granted port's ack SHALL be high for exactly the DONE cycle, and its err SHALL be valid in that same cycle; a write SHALL also ack, with rdata unchanged.
REQ-028 Latency SHALL be fixed: with req sampled at edge E0, ack SHALL be high in the cycle after E2; the next grant SHALL be sampled no earlier than E4.
REQ-029 A requester SHALL drop or replace its req on the edge where it sees ack.
REQ-030 An ungranted port SHALL keep ack=0 and hold its previous rdata.

Reset
REQ-031 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE and all outputs (acks, errs, rdatas, ram_*, busy) SHALL go to 0.
REQ-032 Reset SHALL set last-grant to port I.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no ack; a write already strobed in ISSUE may have completed in the RAM.

Verification
REQ-034 Port D writes word 0xF00FF176 to address 200 and then reads it as a word -> d_ack after 3 edges each, d_rdata=0xF00FF176, d_err=0.
REQ-035 Half-word reads of address 200 with d_sign=1 and then d_sign=0 -> 0xFFFFF176, then 0x0000F176.
REQ-036 i_req and d_req high together from reset, both held -> grant order D, I, D, I; each ack lasts one cycle and busy drops for exactly one cycle between grants.
REQ-037 Word read at 253, half-word write at 0, and word read at 0xFFFFFFFE -> err=1 and rdata=0 for each, no RAM strobe; a half-word read at 254 -> err=0.
REQ-038 rst_n low in the WAIT state of a read -> no ack, all outputs 0 next cycle, and the next tie goes to port D.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported RAM.
// Fixed four-state transaction: IDLE -> ISSUE -> WAIT -> DONE -> IDLE, with
// round-robin on ties, address-limit error checking and half-word extension.
module mem_arbiter #(
   parameter int unsigned MEM_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_word,
   input  logic        d_sign,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        ram_read,
   output logic        ram_write,
   output logic        ram_word,
   output logic        ram_sign,
   output logic [31:0] ram_address,
   output logic [31:0] ram_dataIn,
   input  logic [31:0] ram_dataOut,
   output logic        busy
);

   localparam int unsigned DW = 32;
   localparam int unsigned LW = 33;
   localparam logic [LW-1:0] LIMIT = LW'(MEM_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   // Transaction captured at grant time and held until the next grant
   typedef struct packed {
      port_t         port;
      logic          we;
      logic          word;
      logic          sign;
      logic          err;
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
   } xact_t;

   state_t        state, state_nxt;
   xact_t         cur, cur_nxt;
   port_t         last, last_nxt;
   logic          gnt_d;
   logic [LW-1:0] end_addr;
   logic [DW-1:0] rd_val;

   logic          i_ack_nxt, i_err_nxt, d_ack_nxt, d_err_nxt;
   logic [DW-1:0] i_rdata_nxt, d_rdata_nxt;
   logic          ram_read_nxt, ram_write_nxt, ram_word_nxt, busy_nxt;

   assign ram_address = cur.addr;
   assign ram_dataIn  = cur.wdata;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, grant decision and next values of all registered outputs
   always_comb begin
      state_nxt   = state;
      cur_nxt     = cur;
      last_nxt    = last;
      gnt_d       = 1'b0;
      end_addr    = '0;
      rd_val      = '0;
      i_ack_nxt   = 1'b0;
      i_err_nxt   = 1'b0;
      d_ack_nxt   = 1'b0;
      d_err_nxt   = 1'b0;
      i_rdata_nxt = i_rdata;
      d_rdata_nxt = d_rdata;

      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               // Tie goes to whichever port was not granted last
               gnt_d         = d_req && (!i_req || (last == PORT_I));
               cur_nxt.port  = gnt_d ? PORT_D : PORT_I;
               cur_nxt.we    = gnt_d && d_we;
               cur_nxt.word  = gnt_d ? d_word : 1'b1;
               cur_nxt.sign  = gnt_d && d_sign;
               cur_nxt.addr  = gnt_d ? d_addr : i_addr;
               cur_nxt.wdata = gnt_d ? d_wdata : '0;
               // 33-bit end address so a 32-bit wrap is out of range
               end_addr      = {1'b0, cur_nxt.addr} + (cur_nxt.word ? LW'(3) : LW'(1));
               cur_nxt.err   = (cur_nxt.we && !cur_nxt.word) || (end_addr > LIMIT);
               last_nxt      = cur_nxt.port;
               state_nxt     = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            state_nxt = DONE;
            if (cur.err)       rd_val = '0;
            else if (cur.word) rd_val = ram_dataOut;
            else if (cur.sign) rd_val = {{16{ram_dataOut[15]}}, ram_dataOut[15:0]};
            else               rd_val = {16'h0000, ram_dataOut[15:0]};
            if (cur.port == PORT_D) begin
               d_ack_nxt = 1'b1;
               d_err_nxt = cur.err;
               if (cur.err || !cur.we) d_rdata_nxt = rd_val;
            end else begin
               i_ack_nxt = 1'b1;
               i_err_nxt = cur.err;
               if (cur.err || !cur.we) i_rdata_nxt = rd_val;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      ram_read_nxt  = (state_nxt == ISSUE) && !cur_nxt.err && !cur_nxt.we;
      ram_write_nxt = (state_nxt == ISSUE) && !cur_nxt.err &&  cur_nxt.we;
      ram_word_nxt  = (state_nxt != IDLE);
      busy_nxt      = (state_nxt != IDLE);
   end

   // Transaction latch, round-robin memory and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur       <= '0;
         last      <= PORT_I;
         i_ack     <= 1'b0;
         i_err     <= 1'b0;
         i_rdata   <= '0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= '0;
         ram_read  <= 1'b0;
         ram_write <= 1'b0;
         ram_word  <= 1'b0;
         ram_sign  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cur       <= cur_nxt;
         last      <= last_nxt;
         i_ack     <= i_ack_nxt;
         i_err     <= i_err_nxt;
         i_rdata   <= i_rdata_nxt;
         d_ack     <= d_ack_nxt;
         d_err     <= d_err_nxt;
         d_rdata   <= d_rdata_nxt;
         ram_read  <= ram_read_nxt;
         ram_write <= ram_write_nxt;
         ram_word  <= ram_word_nxt;
         ram_sign  <= 1'b0;
         busy      <= busy_nxt;
      end
   end

endmodule
